// File: rtl/power_arbiter.sv
// -----------------------------------------------------------------------------
// power_arbiter
//
// Round-robin front-end that shares one `power` pipeline between NUM_REQ
// requesters. One request is granted per cycle and forwarded to the pipeline.
// A tag shift register follows every issued item so that each result coming
// back from `power` can be routed to the requester that issued it.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   en           in   grant enable (0 = stop accepting, in-flight items drain)
//   req_valid    in   per-requester request strobe
//   req_data     in   per-requester operand, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  one-hot grant (combinational)
//   pwr_valid    out  issue strobe to power.i_valid (registered)
//   pwr_data     out  operand to power.i_data (registered)
//   pwr_o_valid  in   result strobe from power.o_valid
//   pwr_o_data   in   result from power.o_data
//   rsp_valid    out  one-hot result strobe (registered)
//   rsp_data     out  result (registered)
//   rsp_id       out  owner of rsp_data (registered)
//   outstanding  out  accepted but not yet responded item count
//   err          out  sticky tag/pipeline mismatch flag
// -----------------------------------------------------------------------------
module power_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int PIPE_LATENCY = 3,
    localparam int ID_W         = $clog2(NUM_REQ),
    localparam int OUT_W        = $clog2(PIPE_LATENCY + 2) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pwr_valid,
    output logic [DATA_WIDTH-1:0]         pwr_data,
    input  logic                          pwr_o_valid,
    input  logic [63:0]                   pwr_o_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [63:0]                   rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic [OUT_W-1:0]              outstanding,
    output logic                          err
);

    // A tag enters stage 0 together with pwr_valid; power then needs one edge
    // to sample i_valid and PIPE_LATENCY more to present o_valid, so the tail
    // sits PIPE_LATENCY+1 edges behind stage 0 and lines up with pwr_o_valid.
    localparam int TAG_DEPTH = PIPE_LATENCY + 2;

    logic [ID_W-1:0]                  last_q,        last_d;
    logic                             pwr_valid_q,   pwr_valid_d;
    logic [DATA_WIDTH-1:0]            pwr_data_q,    pwr_data_d;
    logic [TAG_DEPTH-1:0]             tag_valid_q,   tag_valid_d;
    logic [TAG_DEPTH-1:0][ID_W-1:0]   tag_id_q,      tag_id_d;
    logic [NUM_REQ-1:0]               rsp_valid_q,   rsp_valid_d;
    logic [63:0]                      rsp_data_q,    rsp_data_d;
    logic [ID_W-1:0]                  rsp_id_q,      rsp_id_d;
    logic [OUT_W-1:0]                 outstanding_q, outstanding_d;
    logic                             err_q,         err_d;

    logic [NUM_REQ-1:0]               req_ready_s;
    logic [ID_W-1:0]                  grant_id_s;
    logic                             found_s;
    logic                             accept_s;
    logic                             tail_valid_s;
    logic [ID_W-1:0]                  tail_id_s;

    // Round-robin grant: scan last+1, last+2, ... and grant the first valid one.
    always_comb begin
        int  idx;
        logic take;
        req_ready_s = '0;
        grant_id_s  = last_q;
        found_s     = 1'b0;
        idx         = 0;
        take        = 1'b0;
        if (en && !reset) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx              = (int'(last_q) + i) % NUM_REQ;
                take             = !found_s && req_valid[idx];
                req_ready_s[idx] = take;
                grant_id_s       = take ? ID_W'(idx) : grant_id_s;
                found_s          = found_s | take;
            end
        end else begin
            req_ready_s = '0;
        end
    end

    // The grant only exists for a valid requester, so any grant is an accept.
    assign accept_s  = |req_ready_s;
    assign req_ready = req_ready_s;

    // Next-state logic for issue, tag pipeline, response and bookkeeping.
    always_comb begin
        last_d        = last_q;
        pwr_valid_d   = accept_s;
        pwr_data_d    = pwr_data_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_id_d      = rsp_id_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (accept_s) begin
            last_d     = grant_id_s;
            pwr_data_d = req_data[int'(grant_id_s)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            last_d     = last_q;
            pwr_data_d = pwr_data_q;
        end

        // Stage 0 id is don't-care when the stage is invalid.
        tag_valid_d  = {tag_valid_q[TAG_DEPTH-2:0], accept_s};
        tag_id_d     = {tag_id_q[TAG_DEPTH-2:0], grant_id_s};
        tail_valid_s = tag_valid_q[TAG_DEPTH-1];
        tail_id_s    = tag_id_q[TAG_DEPTH-1];

        case ({tail_valid_s, pwr_o_valid})
            2'b11: begin
                rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << tail_id_s;
                rsp_id_d    = tail_id_s;
                rsp_data_d  = pwr_o_data;
            end
            // Result without a tag, or tag without a result.
            2'b10, 2'b01: begin
                err_d = 1'b1;
            end
            default: begin
                rsp_valid_d = '0;
            end
        endcase

        // A valid tail retires one item whether it responded or was dropped.
        case ({accept_s, tail_valid_s})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1'b1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1'b1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q        <= ID_W'(NUM_REQ - 1);
            pwr_valid_q   <= 1'b0;
            pwr_data_q    <= '0;
            tag_valid_q   <= '0;
            tag_id_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= 64'h0;
            rsp_id_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            last_q        <= last_d;
            pwr_valid_q   <= pwr_valid_d;
            pwr_data_q    <= pwr_data_d;
            tag_valid_q   <= tag_valid_d;
            tag_id_q      <= tag_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_id_q      <= rsp_id_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign pwr_valid   = pwr_valid_q;
    assign pwr_data    = pwr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign outstanding = outstanding_q;
    assign err         = err_q;

endmodule

// File: tb/tb_power_arbiter.sv
// -----------------------------------------------------------------------------
// tb_power_arbiter
//
// Drives power_arbiter with directed and random traffic. `power` is stood in
// by a delay line whose o_valid rises PIPE_LATENCY cycles after it samples
// i_valid, with o_data = {32'h0, i_data}. Expected outputs come from a
// transaction-level model: a round-robin rule, a queue of in-flight items
// each carrying the cycle on which its response is due, and a sticky error.
// -----------------------------------------------------------------------------
module tb_power_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int P   = 3;
    localparam int IDW = 2;
    localparam int OW  = 4;

    logic            clk = 1'b0;
    logic            reset, en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            pwr_valid;
    logic [DW-1:0]   pwr_data;
    logic            pwr_o_valid;
    logic [63:0]     pwr_o_data;
    logic [N-1:0]    rsp_valid;
    logic [63:0]     rsp_data;
    logic [IDW-1:0]  rsp_id;
    logic [OW-1:0]   outstanding;
    logic            err;

    always #5 clk = ~clk;

    power_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PIPE_LATENCY(P)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pwr_valid(pwr_valid), .pwr_data(pwr_data),
        .pwr_o_valid(pwr_o_valid), .pwr_o_data(pwr_o_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .outstanding(outstanding), .err(err)
    );

    // Stand-in for `power`, reset together with the arbiter. inj forces a
    // result with no matching tag, sup swallows the result currently leaving.
    logic [P:0]         sv;
    logic [P:0][DW-1:0] sd;
    logic               inj, sup;
    always_ff @(posedge clk) begin
        if (reset) begin
            sv <= '0;
            sd <= '0;
        end else begin
            sv <= {sv[P-1:0], pwr_valid};
            sd <= {sd[P-1:0], pwr_data};
        end
    end
    assign pwr_o_valid = (sv[P] & ~sup) | inj;
    assign pwr_o_data  = {32'h0, sd[P]};

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [63:0] data;
    } item_t;

    item_t       q[$];
    int          cyc = 0;
    int          m_last = N - 1;
    logic        m_pwr_valid = 1'b0;
    logic [DW-1:0] m_pwr_data = '0;
    logic [N-1:0]  m_rsp_valid = '0;
    logic [IDW-1:0] m_rsp_id = '0;
    logic [63:0]   m_rsp_data = 64'h0;
    logic          m_err = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [N-1:0] model_grant();
        int k;
        if (reset || !en) return '0;
        for (int i = 1; i <= N; i++) begin
            k = (m_last + i) % N;
            if (req_valid[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    // Advance the model across the coming clock edge (edge number cyc).
    task automatic model_edge();
        logic [N-1:0] g;
        bit has_tag, has_res;
        item_t it;
        g = model_grant();
        if (reset) begin
            q.delete();
            m_last = N - 1; m_pwr_valid = 1'b0; m_pwr_data = '0;
            m_rsp_valid = '0; m_rsp_id = '0; m_rsp_data = 64'h0; m_err = 1'b0;
        end else begin
            has_tag = (q.size() > 0) && (q[0].due == cyc);
            has_res = (has_tag && !sup) || inj;
            m_rsp_valid = '0;
            if (has_tag && has_res) begin
                m_rsp_valid = N'(1) << q[0].id;
                m_rsp_id    = IDW'(q[0].id);
                m_rsp_data  = q[0].data;
            end else if (has_tag || has_res) begin
                m_err = 1'b1;
            end
            if (has_tag) void'(q.pop_front());
            m_pwr_valid = (g != '0);
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    it.due  = cyc + P + 2;
                    it.id   = k;
                    it.data = {32'h0, req_data[k*DW +: DW]};
                    q.push_back(it);
                    m_pwr_data = req_data[k*DW +: DW];
                    m_last     = k;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; req_valid = '0; inj = 1'b0; sup = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_data();
        req_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; en = 1'b1; req_valid = '1; inj = 1'b0; sup = 1'b0; rand_data();
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        tick(); tick();
        reset = 1'b0; req_valid = '0;
        vectors++;
        if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !== 108'b0) begin
            miscompares++;
            $display("FAIL reset_state: got pv=%b pd=%h rv=%b id=%h rd=%h out=%0d err=%b expected all zero",
                     pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err);
        end
    endtask

    task automatic test_single();
        en = 1'b1; req_valid = 4'b0100; req_data = '0; req_data[2*DW +: DW] = 32'h5;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        vectors++;
        if ({pwr_valid, pwr_data} !== {1'b1, 32'h5}) begin
            miscompares++; $display("FAIL single_issue: got %b/%h expected 1/00000005", pwr_valid, pwr_data);
        end
        repeat (5) begin
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL single_model cyc=%0d: got rv=%b id=%0d out=%0d expected rv=%b id=%0d out=%0d",
                                        cyc, rsp_valid, rsp_id, outstanding, m_rsp_valid, m_rsp_id, q.size());
            end
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, outstanding} !== {4'b0100, 2'd2, 64'h5, 4'd0}) begin
            miscompares++; $display("FAIL single_rsp: got rv=%b id=%0d rd=%h out=%0d expected 0100/2/5/0",
                                    rsp_valid, rsp_id, rsp_data, outstanding);
        end
    endtask

    task automatic test_round_robin();
        int peak = 0;
        int got[$];
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            rand_data();
            #1;
            if (c < 8) begin
                vectors++;
                if (req_ready !== (N'(1) << (c % N))) begin
                    miscompares++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, N'(1) << (c % N));
                end
            end
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL rr_model cyc=%0d: got rv=%b id=%0d out=%0d expected rv=%b id=%0d out=%0d",
                                        cyc, rsp_valid, rsp_id, outstanding, m_rsp_valid, m_rsp_id, q.size());
            end
            if (rsp_valid != '0) got.push_back(int'(rsp_id));
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
        vectors++;
        if (peak !== P + 2) begin
            miscompares++; $display("FAIL rr_peak: got %0d expected %0d", peak, P + 2);
        end
        vectors++;
        if (got.size() !== 8) begin
            miscompares++; $display("FAIL rr_count: got %0d expected 8", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== i % N) begin
                miscompares++; $display("FAIL rr_order i=%0d: got %0d expected %0d", i, got[i], i % N);
            end
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] prev_g = '0;
        int starve = 0;
        en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            req_valid = (c >= 12) ? 4'b0000 : ((c % 2 == 0) ? 4'b1010 : 4'b0010);
            rand_data();
            #1;
            vectors++;
            if (req_ready !== model_grant()) begin
                miscompares++; $display("FAIL fair_grant c=%0d: got %b expected %b", c, req_ready, model_grant());
            end
            if (req_valid[3] && prev_g == 4'b0010) begin
                vectors++;
                if (req_ready !== 4'b1000) begin
                    miscompares++; $display("FAIL fair_r3 c=%0d: got %b expected 1000", c, req_ready);
                end
            end
            if (c < 12) begin
                starve = req_ready[1] ? 0 : starve + 1;
                vectors++;
                if (starve > 1) begin
                    miscompares++; $display("FAIL fair_starve c=%0d: got %0d idle cycles expected at most 1", c, starve);
                end
            end
            prev_g = req_ready;
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL fair_model cyc=%0d: got rv=%b id=%0d out=%0d expected rv=%b id=%0d out=%0d",
                                        cyc, rsp_valid, rsp_id, outstanding, m_rsp_valid, m_rsp_id, q.size());
            end
        end
    endtask

    task automatic test_en_gating();
        logic [N-1:0] last_g = '0;
        int li = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 15; c++) begin
            en = (c < 3) || (c >= 7 && c < 10);
            rand_data();
            #1;
            vectors++;
            if (req_ready !== model_grant()) begin
                miscompares++; $display("FAIL en_grant c=%0d: got %b expected %b", c, req_ready, model_grant());
            end
            if (!en) begin
                vectors++;
                if (req_ready !== 4'b0000) begin
                    miscompares++; $display("FAIL en_block c=%0d: got %b expected 0000", c, req_ready);
                end
            end
            if (c == 7) begin
                for (int k = 0; k < N; k++) if (last_g[k]) li = k;
                vectors++;
                if (req_ready !== (N'(1) << ((li + 1) % N))) begin
                    miscompares++; $display("FAIL en_resume: got %b expected %b", req_ready, N'(1) << ((li + 1) % N));
                end
            end
            if (req_ready != '0) last_g = req_ready;
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL en_model cyc=%0d: got rv=%b id=%0d out=%0d expected rv=%b id=%0d out=%0d",
                                        cyc, rsp_valid, rsp_id, outstanding, m_rsp_valid, m_rsp_id, q.size());
            end
        end
        vectors++;
        if (outstanding !== 4'd0) begin
            miscompares++; $display("FAIL en_drain: got %0d expected 0", outstanding);
        end
        req_valid = '0;
    endtask

    task automatic test_mismatch();
        do_reset();
        en = 1'b1;
        inj = 1'b1;
        tick();
        inj = 1'b0;
        vectors++;
        if ({rsp_valid, err} !== {4'b0000, 1'b1}) begin
            miscompares++; $display("FAIL mm_inject: got rv=%b err=%b expected 0000/1", rsp_valid, err);
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 4) ? 4'(($urandom)) : 4'h0;
            rand_data();
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL mm_hold cyc=%0d: got rv=%b out=%0d err=%b expected rv=%b out=%0d err=%b",
                                        cyc, rsp_valid, outstanding, err, m_rsp_valid, q.size(), m_err);
            end
        end
        do_reset();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL mm_clear: got %b expected 0", err);
        end
        en = 1'b1; req_valid = 4'b0010; rand_data();
        tick();
        req_valid = '0;
        repeat (P + 1) tick();
        sup = 1'b1;
        tick();
        sup = 1'b0;
        vectors++;
        if ({rsp_valid, err, outstanding} !== {4'b0000, 1'b1, 4'd0}) begin
            miscompares++; $display("FAIL mm_suppress: got rv=%b err=%b out=%0d expected 0000/1/0", rsp_valid, err, outstanding);
        end
        vectors++;
        if ({rsp_valid, err, outstanding} !== {m_rsp_valid, m_err, OW'(q.size())}) begin
            miscompares++; $display("FAIL mm_model: got rv=%b err=%b expected rv=%b err=%b", rsp_valid, err, m_rsp_valid, m_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        en = 1'b1; req_valid = 4'hF;
        repeat (3) begin
            rand_data();
            tick();
        end
        vectors++;
        if (outstanding !== 4'd3) begin
            miscompares++; $display("FAIL mid_inflight: got %0d expected 3", outstanding);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL mid_ready: got %b expected 0000", req_ready);
        end
        tick();
        reset = 1'b0; req_valid = '0;
        vectors++;
        if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !== 108'b0) begin
            miscompares++; $display("FAIL mid_state: got pv=%b pd=%h rv=%b id=%h rd=%h out=%0d err=%b expected all zero",
                                    pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err);
        end
        repeat (P + 3) begin
            tick();
            vectors++;
            if ({rsp_valid, err, outstanding} !== 9'b0) begin
                miscompares++; $display("FAIL mid_after cyc=%0d: got rv=%b err=%b out=%0d expected 0000/0/0",
                                        cyc, rsp_valid, err, outstanding);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 306; c++) begin
            en        = (c < 300) && ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom);
            rand_data();
            #1;
            vectors++;
            if (req_ready !== model_grant()) begin
                miscompares++; $display("FAIL rand_grant c=%0d: got %b expected %b", c, req_ready, model_grant());
            end
            tick();
            vectors++;
            if ({pwr_valid, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding, err} !==
                {m_pwr_valid, m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, OW'(q.size()), m_err}) begin
                miscompares++; $display("FAIL rand_model cyc=%0d: got pd=%h rv=%b id=%0d rd=%h out=%0d expected pd=%h rv=%b id=%0d rd=%h out=%0d",
                                        cyc, pwr_data, rsp_valid, rsp_id, rsp_data, outstanding,
                                        m_pwr_data, m_rsp_valid, m_rsp_id, m_rsp_data, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_en_gating();
        test_mismatch();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
